// File: rtl/serv_bufreg_seq_if.sv
// Handshake and bus bundle between the bufreg sequencer and its environment.
// The slave modport is the sequencer's view; the master modport is the driver's view.
interface serv_bufreg_seq_if;
  logic       i_start;
  logic       i_we;
  logic       i_byte;
  logic       i_half;
  logic [1:0] i_lsb;
  logic       i_dbus_ack;
  logic [4:0] o_cnt;
  logic       o_cnt0;
  logic       o_cnt1;
  logic       o_bufreg_en;
  logic       o_bufreg_init;
  logic       o_bufreg_loop;
  logic       o_dbus_cyc;
  logic       o_dbus_we;
  logic       o_busy;
  logic       o_done;
  logic       o_misalign;

  modport slave (
    input  i_start, i_we, i_byte, i_half, i_lsb, i_dbus_ack,
    output o_cnt, o_cnt0, o_cnt1, o_bufreg_en, o_bufreg_init, o_bufreg_loop,
           o_dbus_cyc, o_dbus_we, o_busy, o_done, o_misalign
  );

  modport master (
    output i_start, i_we, i_byte, i_half, i_lsb, i_dbus_ack,
    input  o_cnt, o_cnt0, o_cnt1, o_bufreg_en, o_bufreg_init, o_bufreg_loop,
           o_dbus_cyc, o_dbus_we, o_busy, o_done, o_misalign
  );
endinterface

// File: rtl/serv_bufreg_seq.sv
// Memory-operation sequencer: 32-cycle bufreg init, bus request, optional 32-cycle
// load recirculation. All outputs are registered alongside the state.
//
// state  | meaning
// IDLE   | waiting for i_start; all outputs low except one-cycle done/misalign pulses
// INIT   | bufreg shifting in the address, o_cnt 0..31
// BUS    | o_dbus_cyc held until i_dbus_ack
// RUN    | load data recirculating through bufreg, o_cnt 0..31
module serv_bufreg_seq #(
  parameter int ALIGN_CHECK = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  serv_bufreg_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_BUS  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_we;
  logic       r_byte;
  logic       r_half;
  logic [4:0] r_cnt;
  logic       r_cnt0;
  logic       r_cnt1;
  logic       r_bufreg_en;
  logic       r_bufreg_init;
  logic       r_bufreg_loop;
  logic       r_dbus_cyc;
  logic       r_dbus_we;
  logic       r_busy;
  logic       r_done;
  logic       r_misalign;

  logic w_half_acc;
  logic w_word_acc;
  logic w_misaligned;
  logic w_trap;
  logic w_cnt_last;

  // A set byte flag takes precedence, so byte accesses can never trap.
  assign w_half_acc   = r_half & ~r_byte;
  assign w_word_acc   = ~r_half & ~r_byte;
  assign w_misaligned = (w_half_acc & bus.i_lsb[0]) | (w_word_acc & (bus.i_lsb != 2'b00));
  assign w_trap       = (ALIGN_CHECK != 0) && w_misaligned;
  assign w_cnt_last   = (r_cnt == 5'd31);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_byte        <= 1'b0;
      r_half        <= 1'b0;
      r_cnt         <= 5'd0;
      r_cnt0        <= 1'b0;
      r_cnt1        <= 1'b0;
      r_bufreg_en   <= 1'b0;
      r_bufreg_init <= 1'b0;
      r_bufreg_loop <= 1'b0;
      r_dbus_cyc    <= 1'b0;
      r_dbus_we     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state       <= S_INIT;
            r_we          <= bus.i_we;
            r_byte        <= bus.i_byte;
            r_half        <= bus.i_half;
            r_cnt         <= 5'd0;
            r_cnt0        <= 1'b1;
            r_cnt1        <= 1'b0;
            r_bufreg_en   <= 1'b1;
            r_bufreg_init <= 1'b1;
            r_bufreg_loop <= 1'b0;
            r_busy        <= 1'b1;
          end
        end

        S_INIT: begin
          if (w_cnt_last) begin
            r_cnt         <= 5'd0;
            r_cnt0        <= 1'b0;
            r_cnt1        <= 1'b0;
            r_bufreg_en   <= 1'b0;
            r_bufreg_init <= 1'b0;
            if (w_trap) begin
              // Trap returns straight to IDLE without ever raising the bus request.
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_misalign <= 1'b1;
            end else begin
              r_state    <= S_BUS;
              r_dbus_cyc <= 1'b1;
              r_dbus_we  <= r_we;
            end
          end else begin
            r_cnt  <= r_cnt + 5'd1;
            r_cnt0 <= 1'b0;
            r_cnt1 <= (r_cnt == 5'd0);
          end
        end

        S_BUS: begin
          if (bus.i_dbus_ack) begin
            r_dbus_cyc <= 1'b0;
            r_dbus_we  <= 1'b0;
            if (r_we) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state       <= S_RUN;
              r_cnt         <= 5'd0;
              r_cnt0        <= 1'b1;
              r_cnt1        <= 1'b0;
              r_bufreg_en   <= 1'b1;
              r_bufreg_loop <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (w_cnt_last) begin
            r_state       <= S_IDLE;
            r_cnt         <= 5'd0;
            r_cnt0        <= 1'b0;
            r_cnt1        <= 1'b0;
            r_bufreg_en   <= 1'b0;
            r_bufreg_loop <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 5'd1;
            r_cnt0 <= 1'b0;
            r_cnt1 <= (r_cnt == 5'd0);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_cnt         = r_cnt;
  assign bus.o_cnt0        = r_cnt0;
  assign bus.o_cnt1        = r_cnt1;
  assign bus.o_bufreg_en   = r_bufreg_en;
  assign bus.o_bufreg_init = r_bufreg_init;
  assign bus.o_bufreg_loop = r_bufreg_loop;
  assign bus.o_dbus_cyc    = r_dbus_cyc;
  assign bus.o_dbus_we     = r_dbus_we;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_misalign    = r_misalign;

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Scoreboard bench for serv_bufreg_seq: stimulus queues expected done/misalign events,
// a forked monitor pops and checks them; per-cycle output vectors are checked inline.
module tb_serv_bufreg_seq;

  logic clk;
  logic rst;
  int   cyc_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int kind;   // 0 = done, 1 = misalign
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  serv_bufreg_seq_if bus ();
  serv_bufreg_seq_if bus_nc ();

  serv_bufreg_seq #(.ALIGN_CHECK(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  serv_bufreg_seq #(.ALIGN_CHECK(0)) dut_nc (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] ev(input logic [4:0] c, input logic c0, input logic c1,
                                     input logic en, input logic ini, input logic lp,
                                     input logic cy, input logic w, input logic bz);
    return {c, c0, c1, en, ini, lp, cy, w, bz};
  endfunction

  function automatic logic [12:0] obs_m();
    return {bus.o_cnt, bus.o_cnt0, bus.o_cnt1, bus.o_bufreg_en, bus.o_bufreg_init,
            bus.o_bufreg_loop, bus.o_dbus_cyc, bus.o_dbus_we, bus.o_busy};
  endfunction

  function automatic logic [12:0] obs_nc();
    return {bus_nc.o_cnt, bus_nc.o_cnt0, bus_nc.o_cnt1, bus_nc.o_bufreg_en, bus_nc.o_bufreg_init,
            bus_nc.o_bufreg_loop, bus_nc.o_dbus_cyc, bus_nc.o_dbus_we, bus_nc.o_busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_done || bus.o_misalign) begin
        chk("done_misalign_exclusive", 32'(bus.o_done & bus.o_misalign), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event at cycle %0d: done=%0b misalign=%0b, none expected",
                   cyc_n, bus.o_done, bus.o_misalign);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 32'(bus.o_misalign), 32'(e.kind));
          chk("event_cycle", 32'(cyc_n), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic do_op(input logic we, input logic byt, input logic half, input logic [1:0] lsb,
                       input int ad, input logic mis, input logic spurious);
    int   k;
    exp_t e;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_we    = we;
    bus.i_byte  = byt;
    bus.i_half  = half;
    bus.i_lsb   = lsb;
    k = cyc_n;
    e.kind = mis ? 1 : 0;
    e.cyc  = mis ? k + 33 : (we ? k + 34 + ad : k + 66 + ad);
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble the size/direction inputs so only the latched copies can be right.
    bus.i_start = 1'b0;
    bus.i_we    = ~we;
    bus.i_byte  = 1'b0;
    bus.i_half  = ~half;
    for (int i = 0; i < 32; i++) begin
      chk("init_vec", 32'(obs_m()), 32'(ev(5'(i), i == 0, i == 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)));
      if (spurious) bus.i_start = (i == 5);
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    if (mis) begin
      chk("trap_idle_vec", 32'(obs_m()), 32'd0);
    end else begin
      for (int d = 0; d <= ad; d++) begin
        chk("bus_vec", 32'(obs_m()), 32'(ev(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, we, 1'b1)));
        if (spurious) bus.i_start = (d == 0);
        bus.i_dbus_ack = (d == ad);
        @(negedge clk);
      end
      bus.i_dbus_ack = 1'b0;
      bus.i_start    = 1'b0;
      if (!we) begin
        for (int i = 0; i < 32; i++) begin
          chk("run_vec", 32'(obs_m()), 32'(ev(5'(i), i == 0, i == 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)));
          @(negedge clk);
        end
      end
      chk("end_idle_vec", 32'(obs_m()), 32'd0);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.i_start = 1'b0;  bus.i_we = 1'b0;  bus.i_byte = 1'b0;  bus.i_half = 1'b0;
    bus.i_lsb = 2'b00;   bus.i_dbus_ack = 1'b0;
    bus_nc.i_start = 1'b0;  bus_nc.i_we = 1'b0;  bus_nc.i_byte = 1'b0;  bus_nc.i_half = 1'b0;
    bus_nc.i_lsb = 2'b00;   bus_nc.i_dbus_ack = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_vec", 32'(obs_m()), 32'd0);
    chk("reset_pulses", 32'({bus.o_done, bus.o_misalign}), 32'd0);
    chk("reset_vec_nc", 32'(obs_nc()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_vec", 32'(obs_m()), 32'd0);

    do_op(1'b1, 1'b0, 1'b0, 2'b00, 3, 1'b0, 1'b0);  // store word, aligned, ack after 3 waits
    do_op(1'b0, 1'b1, 1'b0, 2'b11, 0, 1'b0, 1'b0);  // load byte, immediate ack
    do_op(1'b0, 1'b0, 1'b1, 2'b01, 0, 1'b1, 1'b0);  // load half at odd address -> trap
    do_op(1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0, 1'b0);  // store half, aligned
    do_op(1'b1, 1'b0, 1'b0, 2'b10, 0, 1'b1, 1'b0);  // store word at +2 -> trap
    do_op(1'b1, 1'b1, 1'b0, 2'b01, 2, 1'b0, 1'b0);  // store byte, never traps
    do_op(1'b0, 1'b0, 1'b1, 2'b10, 1, 1'b0, 1'b0);  // load half, aligned

    // Spurious acks while idle must not move the sequencer.
    @(negedge clk);
    bus.i_dbus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_spurious_ack", 32'(obs_m()), 32'd0);
    end
    bus.i_dbus_ack = 1'b0;
    do_op(1'b0, 1'b0, 1'b0, 2'b00, 2, 1'b0, 1'b1);  // load word with start pulses while busy

    // Async reset while the bus request is up.
    @(negedge clk);
    bus.i_start = 1'b1;  bus.i_we = 1'b0;  bus.i_byte = 1'b0;  bus.i_half = 1'b0;  bus.i_lsb = 2'b00;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (32) @(negedge clk);
    chk("pre_reset_cyc", 32'(bus.o_dbus_cyc), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_vec", 32'(obs_m()), 32'd0);
    chk("async_reset_pulses", 32'({bus.o_done, bus.o_misalign}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 1'b1, 1'b0, 2'b11, 0, 1'b0, 1'b0);  // store byte right after reset

    // Same misaligned half load with the trap disabled proceeds to the bus.
    @(negedge clk);
    bus_nc.i_start = 1'b1;  bus_nc.i_we = 1'b0;  bus_nc.i_half = 1'b1;  bus_nc.i_lsb = 2'b01;
    k = cyc_n;
    @(negedge clk);
    bus_nc.i_start = 1'b0;
    repeat (32) @(negedge clk);
    chk("nc_bus_cycle", 32'(cyc_n), 32'(k + 33));
    chk("nc_bus_vec", 32'(obs_nc()), 32'(ev(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)));
    chk("nc_no_trap", 32'(bus_nc.o_misalign), 32'd0);
    bus_nc.i_dbus_ack = 1'b1;
    @(negedge clk);
    bus_nc.i_dbus_ack = 1'b0;
    repeat (32) @(negedge clk);
    chk("nc_done", 32'(bus_nc.o_done), 32'd1);

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
